// File: rtl/nano9k_buttons.sv
// nano9k_buttons
//
// Conditions the two raw, active-low, bouncing user push buttons on the
// Tang Nano 9K. It produces a debounced press state for each button, plus a
// one-cycle press strobe and a one-cycle release strobe. It also keeps a
// 6-bit up/down count: button 0 counts up and button 1 counts down.
//
// Ports
//   clk            board clock (27 MHz); every register uses its rising edge
//   rst            synchronous, active-high reset
//   btn_n[1:0]     raw button pads, 0 = pressed, asynchronous to clk
//   pressed[1:0]   debounced state, 1 = held
//   press_pulse    one-cycle strobe for each accepted press
//   release_pulse  one-cycle strobe for each accepted release
//   count[5:0]     modulo-64 up/down press counter

module nano9k_buttons #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_n,
    output logic [1:0] pressed,
    output logic [1:0] press_pulse,
    output logic [1:0] release_pulse,
    output logic [5:0] count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    // Stage p0/p1: two-flop synchroniser. It resets to the released level.
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
        end
    end

    assign raw = ~sync_p1;

    // Stage p2: per-channel debounce FSM with its registered strobes.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             press_nxt;
        logic             release_nxt;
        logic             press_q;
        logic             release_q;

        // A level that differs from the accepted state must last through the
        // terminal count. Any sample back at the accepted level restarts the
        // window.
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt + 1'b1;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state)
                RELEASED: begin
                    if (!raw[i]) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end
                end
                PRESSED: begin
                    if (raw[i]) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= RELEASED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        assign pressed[i]       = (state == PRESSED);
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end

    // Stage p3: the up/down counter follows the strobes by one cycle.
    // Presses on both buttons in the same cycle cancel each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 6'd0;
        end else begin
            case (press_pulse)
                2'b01:   count <= count + 6'd1;
                2'b10:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_nano9k_buttons.sv
module tb_nano9k_buttons;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] pressed;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [5:0] count;

    nano9k_buttons #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .count         (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model. The pads reach the debouncer two edges late. A
    // button's accepted level flips once it has seen D consecutive edges of
    // the opposite level. The counter applies the previous cycle's strobes
    // modulo 64.
    bit [1:0] hist [2];
    bit [1:0] m_pressed;
    bit [1:0] m_pp;
    bit [1:0] m_rp;
    int       m_run [2];
    int       m_count;
    bit [1:0] m_raw;

    always @(posedge clk) begin
        if (rst) begin
            hist[0] = 2'b11;
            hist[1] = 2'b11;
            m_pressed = 2'b00;
            m_pp = 2'b00;
            m_rp = 2'b00;
            m_run[0] = 0;
            m_run[1] = 0;
            m_count = 0;
        end else begin
            m_raw   = ~hist[1];
            hist[1] = hist[0];
            hist[0] = btn_n;
            if (m_pp == 2'b01)      m_count = (m_count + 1) % 64;
            else if (m_pp == 2'b10) m_count = (m_count + 63) % 64;
            m_pp = 2'b00;
            m_rp = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (m_raw[c] != m_pressed[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_pressed[c] = m_raw[c];
                        m_run[c] = 0;
                        if (m_raw[c]) m_pp[c] = 1'b1;
                        else          m_rp[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    end

    int pp_cnt [2];
    int rp_cnt [2];

    always @(negedge clk) begin
        if (chk_en) begin
            check("pressed", int'(pressed), int'(m_pressed));
            check("press_pulse", int'(press_pulse), int'(m_pp));
            check("release_pulse", int'(release_pulse), int'(m_rp));
            check("count", int'(count), m_count);
            for (int c = 0; c < 2; c++) begin
                pp_cnt[c] += int'(press_pulse[c]);
                rp_cnt[c] += int'(release_pulse[c]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    int runs [4] = '{7, 3, 7, 5};
    int base;

    initial begin
        pp_cnt[0] = 0; pp_cnt[1] = 0;
        rp_cnt[0] = 0; rp_cnt[1] = 0;

        // Reset, then idle with both buttons released
        rst = 1'b1;
        btn_n = 2'b11;
        tick(3);
        chk_en = 1'b1;
        check("rst_pressed", int'(pressed), 0);
        check("rst_pulses", int'(press_pulse | release_pulse), 0);
        check("rst_count", int'(count), 0);
        rst = 1'b0;
        tick(50);
        check("idle_press_strobes", pp_cnt[0] + pp_cnt[1], 0);
        check("idle_release_strobes", rp_cnt[0] + rp_cnt[1], 0);
        check("idle_count", int'(count), 0);

        // Clean press and release on button 0
        btn_n[0] = 1'b0;
        tick(9);
        check("press_not_early", int'(pressed[0]), 0);
        tick(1);
        check("press_edge9_pressed", int'(pressed[0]), 1);
        check("press_edge9_pulse", int'(press_pulse), 1);
        tick(1);
        check("press_pulse_single", int'(press_pulse), 0);
        check("press_count", int'(count), 1);
        btn_n[0] = 1'b1;
        tick(9);
        check("release_not_early", int'(release_pulse), 0);
        tick(1);
        check("release_pulse", int'(release_pulse), 1);
        check("release_pressed", int'(pressed[0]), 0);
        tick(1);
        check("release_count", int'(count), 1);

        // Bounce on button 1 is rejected, then a solid hold is accepted
        do_reset(2);
        base = pp_cnt[1];
        for (int r = 0; r < 4; r++) begin
            btn_n[1] = (r % 2 == 0) ? 1'b0 : 1'b1;
            tick(runs[r]);
        end
        check("bounce_no_strobe", pp_cnt[1] - base, 0);
        check("bounce_not_pressed", int'(pressed[1]), 0);
        btn_n[1] = 1'b0;
        tick(12);
        check("bounce_then_hold_strobes", pp_cnt[1] - base, 1);
        check("bounce_count", int'(count), 63);
        btn_n[1] = 1'b1;
        tick(12);

        // Both buttons pressed on the same edge
        do_reset(2);
        btn_n = 2'b00;
        tick(10);
        check("simul_pulse", int'(press_pulse), 3);
        tick(1);
        check("simul_pulse_gone", int'(press_pulse), 0);
        check("simul_count", int'(count), 0);
        btn_n = 2'b11;
        tick(12);

        // Wrap through 64 presses, then one press down
        do_reset(2);
        for (int k = 0; k < 64; k++) begin
            btn_n[0] = 1'b0;
            tick(11);
            if (k == 62) check("wrap_count_63", int'(count), 63);
            btn_n[0] = 1'b1;
            tick(11);
        end
        check("wrap_count_0", int'(count), 0);
        btn_n[1] = 1'b0;
        tick(11);
        check("wrap_down_63", int'(count), 63);
        btn_n[1] = 1'b1;
        tick(11);

        // Reset in the middle of debounce, then again while held
        do_reset(2);
        btn_n[0] = 1'b0;
        tick(7);
        rst = 1'b1;
        tick(1);
        check("midrst_pressed", int'(pressed), 0);
        check("midrst_pulse", int'(press_pulse), 0);
        rst = 1'b0;
        tick(9);
        check("midrst_pulse_not_early", int'(press_pulse[0]), 0);
        tick(1);
        check("midrst_pulse_edge10", int'(press_pulse[0]), 1);
        tick(3);
        check("held_before_rst", int'(pressed[0]), 1);
        rst = 1'b1;
        tick(1);
        check("heldrst_pressed", int'(pressed), 0);
        check("heldrst_count", int'(count), 0);
        rst = 1'b0;
        tick(9);
        check("heldrst_not_early", int'(press_pulse[0]), 0);
        tick(1);
        check("heldrst_pulse_edge10", int'(press_pulse[0]), 1);
        tick(1);
        check("heldrst_count_after", int'(count), 1);
        btn_n[0] = 1'b1;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nano9k_buttons.md
# nano9k_buttons

Input-side companion to the LED counter top on the Tang Nano 9K board. It takes the two raw, active-low, bouncing user push buttons and produces clean, registered press state and single-cycle press and release strobes. It also maintains a 6-bit up/down count that the top level can route to `leds[5:0]`. It sits directly behind the button pads, in the 27 MHz board clock domain.

## Interface

Parameters
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles needed to accept a level change (10 ms at 27 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. Derived; do not override.

Ports
- `clk`  in  1  board clock, 27 MHz; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_n`  in  2  raw button pads; 0 = pressed; asynchronous to `clk`.
- `pressed`  out  2  debounced state; 1 = held.
- `press_pulse`  out  2  one-cycle strobe on each accepted press.
- `release_pulse`  out  2  one-cycle strobe on each accepted release.
- `count`  out  6  up/down press counter.

## Operation

The two buttons are handled as identical, independent channels `i` = 0 and 1.

- **Synchroniser:** a 2-flop chain per bit samples `btn_n`. Reset value is 1 (released). Its output is `s[i]`, and the sampled level is `raw[i] = ~s[i]`.
- **Debounce counter:** per channel, `cnt[i]` is `CNT_W` bits wide.
  - If `raw[i] == pressed[i]`: `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `pressed[i] <= raw[i]` and `cnt[i] <= 0`.
  - Otherwise: `cnt[i] <= cnt[i]+1`.
- **Glitch rejection:** any return to the accepted level before the terminal count zeroes the counter. A bounce therefore has to persist for a full window to be accepted.
- **Strobes:**
  - `press_pulse[i]` is registered and asserted in exactly the cycle `pressed[i]` first reads 1.
  - `release_pulse[i]` is registered and asserted in exactly the cycle `pressed[i]` first reads 0.
  - Each strobe lasts one cycle per accepted transition.
- **Counter:** `count` updates one cycle after the strobes.
  - `press_pulse == 2'b01`: `count + 1`.
  - `press_pulse == 2'b10`: `count - 1`.
  - `2'b11` or `2'b00`: unchanged.
  - Arithmetic is modulo 64: 63+1 → 0 and 0−1 → 63.
- **Reset:** when `rst` is high at an edge, every register takes its reset value at that edge, regardless of the current state.
  - A button still held when reset is released is treated as a new press. It is debounced again and produces `press_pulse` with the normal latency.
- **State machine:** each channel is a 2-state machine, RELEASED ↔ PRESSED. The transition is gated by the terminal count.

## Timing

- **Reset values:** `pressed` = 0, `press_pulse` = 0, `release_pulse` = 0, `count` = 0, `cnt` = 0, synchroniser = all 1.
- **Press latency:** let edge E0 be the first edge at which `btn_n[i]` is sampled low and held.
  - `pressed[i]` and `press_pulse[i]` read 1 after edge E0 + `DEBOUNCE_CYCLES` + 1, i.e. `DEBOUNCE_CYCLES`+2 edges including E0.
  - `count` changes one edge later.
- **Release latency:** identical, mirrored.
- **Minimum accepted level:** a change must be held for at least `DEBOUNCE_CYCLES` consecutive synchronised cycles.
- **Throughput:** one accepted transition per channel per `DEBOUNCE_CYCLES` cycles at most.
- **Combinational paths:** none from input to output; all outputs come straight from flops.

## Test plan

Simulate with `DEBOUNCE_CYCLES` = 8.

1. **Reset:** `btn_n` = 2'b11 with `rst` high for 3 cycles → all outputs 0. Hold `btn_n` at 11 for 50 cycles → no strobes, `count` = 0.
2. **Clean press/release:** drive `btn_n[0]` low from edge E0.
   - `pressed[0]` and a single `press_pulse[0]` appear after edge E0+9.
   - `count` = 1 after E0+10.
   - Drive it high again → `release_pulse[0]` after 10 edges; `count` stays 1.
3. **Bounce:** toggle `btn_n[1]` with runs of 7,3,7,5 low/high cycles.
   - Expect no strobe and `pressed[1]` = 0.
   - Then hold low for 10 cycles → exactly one `press_pulse[1]` and `count` = 63.
4. **Simultaneous presses:** drive both buttons low on the same edge.
   - `press_pulse` = 2'b11 for one cycle.
   - `count` is unchanged at 0.
5. **Wrap:** apply 64 debounced presses on button 0 → `count` goes 63 → 0. A further press on button 1 → `count` = 63.
6. **Reset mid-operation:** hold `btn_n[0]` low and assert `rst` for 1 cycle at `cnt` = 5 and again while `pressed[0]` = 1.
   - Each time, outputs clear at that edge.
   - `press_pulse[0]` reappears 10 edges after `rst` drops, counting the first sampling edge.
